// File: rtl/uart_rx.sv
// 8N1 UART receiver with a two-flop input synchronizer and mid-bit sampling.
// The bit timing is derived from CLOCK_FREQ/BAUD_RATE. The data output holds the last well-framed byte.
//
// state | meaning
// IDLE  | line idle, waiting for rx_s low
// START | counting to mid start bit, rejecting glitches
// DATA  | sampling 8 data bits LSB first at mid-bit
// STOP  | sampling the stop bit, then pulse valid or frame_err
module uart_rx #(
    parameter int BAUD_RATE  = 19200,
    parameter int CLOCK_FREQ = 12000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data,
    output logic       valid,
    output logic       frame_err,
    output logic       busy
);

    localparam int CLKS_PER_BIT = CLOCK_FREQ / BAUD_RATE;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CTR_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

    localparam logic [CTR_W-1:0] CTR_HALF = CTR_W'(HALF_BIT - 1);
    localparam logic [CTR_W-1:0] CTR_LAST = CTR_W'(CLKS_PER_BIT - 1);
    localparam logic [CTR_W-1:0] CTR_ONE  = CTR_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t           state, state_nx;
    logic [CTR_W-1:0] ctr, ctr_nx;
    logic [2:0]       bit_idx, bit_idx_nx;
    logic [7:0]       shreg, shreg_nx;
    logic [7:0]       data_nx;
    logic             valid_nx, frame_err_nx;
    logic             rx_m, rx_s;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_m <= 1'b1;
            rx_s <= 1'b1;
        end else begin
            rx_m <= rx;
            rx_s <= rx_m;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            ctr       <= '0;
            bit_idx   <= '0;
            shreg     <= '0;
            data      <= '0;
            valid     <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            state     <= state_nx;
            ctr       <= ctr_nx;
            bit_idx   <= bit_idx_nx;
            shreg     <= shreg_nx;
            data      <= data_nx;
            valid     <= valid_nx;
            frame_err <= frame_err_nx;
        end
    end

    always_comb begin
        state_nx     = state;
        ctr_nx       = ctr;
        bit_idx_nx   = bit_idx;
        shreg_nx     = shreg;
        data_nx      = data;
        valid_nx     = 1'b0;
        frame_err_nx = 1'b0;
        case (state)
            IDLE: begin
                if (!rx_s) begin
                    state_nx = START;
                    ctr_nx   = '0;
                end
            end
            START: begin
                if (ctr == CTR_HALF) begin
                    ctr_nx = '0;
                    // A start bit that is high again at mid-bit is a glitch.
                    if (!rx_s) begin
                        state_nx   = DATA;
                        bit_idx_nx = '0;
                    end else begin
                        state_nx = IDLE;
                    end
                end else begin
                    ctr_nx = ctr + CTR_ONE;
                end
            end
            DATA: begin
                if (ctr == CTR_LAST) begin
                    ctr_nx     = '0;
                    shreg_nx   = {rx_s, shreg[7:1]};
                    bit_idx_nx = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
                        state_nx = STOP;
                    end
                end else begin
                    ctr_nx = ctr + CTR_ONE;
                end
            end
            STOP: begin
                if (ctr == CTR_LAST) begin
                    ctr_nx   = '0;
                    state_nx = IDLE;
                    if (rx_s) begin
                        data_nx  = shreg;
                        valid_nx = 1'b1;
                    end else begin
                        frame_err_nx = 1'b1;
                    end
                end else begin
                    ctr_nx = ctr + CTR_ONE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx. Every cycle it compares the outputs with a timestamp model of the receiver.
// Directed scenarios add literal expectations on top of that per-cycle comparison.
module tb_uart_rx;

    localparam int CPB  = 16;
    localparam int HALF = 8;
    localparam int MAXC = 8192;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] data;
    logic       valid, frame_err, busy;

    uart_rx #(.BAUD_RATE(10), .CLOCK_FREQ(160)) dut (
        .clk(clk), .rst(rst), .rx(rx),
        .data(data), .valid(valid), .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int n_valid = 0;
    int n_ferr  = 0;
    logic [7:0] vlog[$];

    // Line value seen at each rising edge. Edges taken while in reset read as idle (high).
    bit rx_hist [MAXC];

    bit         m_active = 1'b0;
    int         m_start  = 0;
    logic [7:0] m_sh     = 8'h00;
    logic [7:0] m_data   = 8'h00;
    bit         m_valid  = 1'b0;
    bit         m_ferr   = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // The receiver acts on the line value from two edges earlier. A frame whose
    // start is seen at edge s checks the start bit at s+HALF.
    // It samples data bit n at s+HALF+CPB*(n+1) and the stop bit at s+HALF+9*CPB.
    initial begin
        bit rs;
        int off;
        for (int i = 0; i < MAXC; i++) rx_hist[i] = 1'b1;
        forever begin
            @(posedge clk);
            cyc++;
            if (cyc >= MAXC) begin
                $display("FAIL cycle_budget: got %0d cycles, expected fewer than %0d", cyc, MAXC);
                $fatal(1, "cycle budget exhausted");
            end
            rx_hist[cyc] = rst ? rx : 1'b1;
            if (!rst) begin
                m_active = 1'b0;
                m_sh     = 8'h00;
                m_data   = 8'h00;
                m_valid  = 1'b0;
                m_ferr   = 1'b0;
            end else begin
                rs      = (cyc >= 2) ? rx_hist[cyc-2] : 1'b1;
                m_valid = 1'b0;
                m_ferr  = 1'b0;
                if (!m_active) begin
                    if (!rs) begin
                        m_active = 1'b1;
                        m_start  = cyc;
                    end
                end else begin
                    off = cyc - m_start;
                    if (off == HALF) begin
                        if (rs) m_active = 1'b0;
                    end else if (off == HALF + 9*CPB) begin
                        if (rs) begin
                            m_data  = m_sh;
                            m_valid = 1'b1;
                        end else begin
                            m_ferr = 1'b1;
                        end
                        m_active = 1'b0;
                    end else if (off > HALF && (off - HALF) % CPB == 0) begin
                        m_sh[(off - HALF)/CPB - 1] = rs;
                    end
                end
            end
            #1;
            check("valid", valid, m_valid);
            check("frame_err", frame_err, m_ferr);
            check("busy", busy, m_active);
            check("data", data, m_data);
            check("valid_ferr_exclusive", valid & frame_err, 0);
            if (valid) begin
                n_valid++;
                vlog.push_back(data);
            end
            if (frame_err) n_ferr++;
        end
    end

    task automatic drive(input bit v, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rx = v;
        end
    endtask

    task automatic send(input logic [7:0] b, input bit stop);
        drive(1'b0, CPB);
        for (int i = 0; i < 8; i++) drive(b[i], CPB);
        drive(stop, CPB);
    endtask

    // A data bit holds its true value for a single cycle, exactly at the sample point.
    // Every other cycle carries the complement, and the stop bit goes high exactly at its sample point.
    function automatic bit tim_val(input int j, input logic [7:0] b);
        int n;
        if (j < CPB) return 1'b0;
        if (j < 9*CPB) begin
            n = (j - CPB) / CPB;
            return (j == 24 + CPB*n) ? b[n] : ~b[n];
        end
        return (j >= 152);
    endfunction

    function automatic logic [31:0] vlog_at(input int idx);
        if (idx < vlog.size()) return {24'h0, vlog[idx]};
        return 32'hFFFF_FFFF;
    endfunction

    initial begin
        int v0, f0, q0;
        #1 rst = 1'b0;
        #2;
        check("rst_data", data, 8'h00);
        check("rst_valid", valid, 0);
        check("rst_ferr", frame_err, 0);
        check("rst_busy", busy, 0);
        repeat (4) @(negedge clk);
        rst = 1'b1;
        drive(1'b1, 5);

        v0 = n_valid; f0 = n_ferr;
        send(8'hA5, 1'b1);
        drive(1'b1, 20);
        check("a5_valid_cnt", n_valid - v0, 1);
        check("a5_ferr_cnt", n_ferr - f0, 0);
        check("a5_data", data, 8'hA5);
        check("a5_model_data", m_data, 8'hA5);
        check("a5_busy_low", busy, 0);

        v0 = n_valid; q0 = vlog.size();
        send(8'h00, 1'b1);
        send(8'hFF, 1'b1);
        drive(1'b1, 20);
        check("b2b_valid_cnt", n_valid - v0, 2);
        check("b2b_first", vlog_at(q0), 8'h00);
        check("b2b_second", vlog_at(q0 + 1), 8'hFF);

        v0 = n_valid; f0 = n_ferr;
        drive(1'b0, 4);
        drive(1'b1, 30);
        check("glitch_valid_cnt", n_valid - v0, 0);
        check("glitch_ferr_cnt", n_ferr - f0, 0);
        check("glitch_data", data, 8'hFF);
        check("glitch_busy", busy, 0);

        v0 = n_valid; f0 = n_ferr;
        send(8'h3C, 1'b0);
        drive(1'b1, 20);
        check("badstop_ferr_cnt", n_ferr - f0, 1);
        check("badstop_valid_cnt", n_valid - v0, 0);
        check("badstop_data", data, 8'hFF);

        drive(1'b0, CPB);
        drive(1'b1, CPB);
        drive(1'b0, CPB);
        drive(1'b1, CPB);
        drive(1'b0, 8);
        check("midframe_busy", busy, 1);
        @(negedge clk);
        rst = 1'b0;
        rx  = 1'b1;
        #1;
        check("midrst_data", data, 8'h00);
        check("midrst_busy", busy, 0);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        drive(1'b1, 10);
        v0 = n_valid;
        send(8'h81, 1'b1);
        drive(1'b1, 20);
        check("postrst_valid_cnt", n_valid - v0, 1);
        check("postrst_data", data, 8'h81);

        v0 = n_valid; f0 = n_ferr;
        for (int j = 0; j < 10*CPB; j++) begin
            @(negedge clk);
            rx = tim_val(j, 8'h6B);
        end
        drive(1'b1, 20);
        check("timing_valid_cnt", n_valid - v0, 1);
        check("timing_ferr_cnt", n_ferr - f0, 0);
        check("timing_data", data, 8'h6B);

        // Break: the line stays low long enough for exactly two frames to end in a framing error.
        v0 = n_valid; f0 = n_ferr;
        drive(1'b0, 306);
        drive(1'b1, 200);
        check("break_ferr_cnt", n_ferr - f0, 2);
        check("break_valid_cnt", n_valid - v0, 0);
        check("break_data", data, 8'h6B);
        check("end_busy", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter BAUD_RATE, default 19200, the serial bit rate in bits/s.
REQ-002 SHALL have parameter CLOCK_FREQ, default 12000000, the clk frequency in Hz.
REQ-003 SHALL derive CLKS_PER_BIT = CLOCK_FREQ/BAUD_RATE (integer divide) and HALF_BIT = CLKS_PER_BIT/2.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port rx, input, 1 bit: the asynchronous serial line, which idles high.
REQ-007 SHALL have port data, output, 8 bits: the last correctly framed byte received.
REQ-008 SHALL have port valid, output, 1 bit: a one-cycle pulse when data updates.
REQ-009 SHALL have port frame_err, output, 1 bit: a one-cycle pulse when the stop bit is low.
REQ-010 SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-011 SHALL pass rx through a two-flop synchronizer (rx_s); all decisions use rx_s only; synchronizer flops reset to 1.
REQ-012 SHALL receive the frame format 8N1: one start bit (0), 8 data bits LSB first, one stop bit (1), no parity.
REQ-013 SHALL implement states IDLE, START, DATA and STOP, encoded in 2 bits.
REQ-014 SHALL use a bit-period counter ctr sized ceil(log2(CLKS_PER_BIT)) bits, with no wrap beyond CLKS_PER_BIT-1, and a 3-bit index bit_idx.
REQ-015 SHALL, in IDLE, go to START with ctr=0 on the first cycle that rx_s==0.
REQ-016 SHALL, in START, increment ctr each cycle; at ctr==HALF_BIT-1, sample rx_s:
  - if rx_s==0: go to DATA with ctr=0 and bit_idx=0;
  - if rx_s==1: treat it as a glitch and return to IDLE with no output pulse.
REQ-017 SHALL, in DATA, increment ctr each cycle; at ctr==CLKS_PER_BIT-1:
  - shift rx_s into the shift register MSB so bit 0 arrives first;
  - set ctr=0 and increment bit_idx;
  - after the sample taken at bit_idx==7, go to STOP.
REQ-018 SHALL, in STOP, at ctr==CLKS_PER_BIT-1, sample rx_s and go to IDLE on the next cycle:
  - if rx_s==1: load data from the shift register and assert valid for exactly one cycle;
  - if rx_s==0: assert frame_err for exactly one cycle and leave data unchanged.
REQ-019 SHALL never assert valid and frame_err in the same cycle.
REQ-020 SHALL hold data stable between valid pulses.
REQ-021 SHALL give each sample point at mid-bit: the data bit n sample occurs HALF_BIT + (n+1)*CLKS_PER_BIT cycles after IDLE sees rx_s fall.
REQ-022 SHALL accept a new start edge in the first IDLE cycle after STOP, allowing back-to-back frames with no extra idle time.
REQ-023 SHALL ignore rx changes between sample points, with no re-synchronization inside a frame.
REQ-024 SHALL, after a framing error with rx held low (break), stay in IDLE only until rx_s==0 is seen, which starts a new frame; repeated frame_err pulses are permitted.

Reset
REQ-025 SHALL, while rst==0, asynchronously force: state=IDLE, ctr=0, bit_idx=0, shift register=0, data=8'h00, valid=0, frame_err=0, busy=0, synchronizer flops=1.
REQ-026 SHALL, when reset is asserted mid-frame, discard the partial byte; after release, the block waits for a fresh falling edge on rx_s.

Verification
Parameters for the bench: CLOCK_FREQ=160, BAUD_RATE=10, giving CLKS_PER_BIT=16 and HALF_BIT=8.
REQ-027 SHALL cover a single frame: send 0xA5 correctly framed -> one valid pulse, data==8'hA5, frame_err stays 0, busy falls after STOP.
REQ-028 SHALL cover back-to-back frames: send 0x00 then 0xFF with no idle gap -> two valid pulses, with data 8'h00 then 8'hFF.
REQ-029 SHALL cover a start glitch: drive rx low for 4 cycles, then high -> return to IDLE, no valid, no frame_err, data unchanged.
REQ-030 SHALL cover a bad stop bit: send 0x3C with stop bit=0 -> one frame_err pulse, no valid, data keeps its previous value.
REQ-031 SHALL cover reset mid-frame: assert rst low during bit 3 of 0x55, release, then send 0x81 -> exactly one valid pulse, with data==8'h81.
REQ-032 SHALL cover sample timing: assert that the DATA samples occur at HALF_BIT+16*(n+1) cycles after IDLE detects rx_s low, with a tolerance of 0 cycles.
